// File: rtl/duty_bcd_if.sv
// Handshake bundle between the duty-cycle meter side and the BCD converter.
// The refresh request is force_req because "force" is a reserved word.
interface duty_bcd_if;
  logic [15:0] duty_in;
  logic        force_req;
  logic [19:0] bcd;
  logic        over;
  logic        valid;
  logic        busy;

  modport master (output duty_in, force_req, input bcd, over, valid, busy);
  modport slave  (input duty_in, force_req, output bcd, over, valid, busy);
endinterface

// File: rtl/duty_bcd_conv.sv
// Rate-limited sequential double-dabble: converts the per-mille duty value to
// five BCD digits only on a value change or forced refresh.
module duty_bcd_conv #(
  parameter int IN_W       = 16,
  parameter int MAX_VAL    = 1000,
  parameter int UPDATE_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  duty_bcd_if.slave  bus
);
  localparam int SW = IN_W + 20;
  localparam int HW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [HW-1:0] HO_INIT  = HW'(UPDATE_DIV - 1);
  localparam logic [3:0]    CNT_LAST = 4'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   sreg;
  logic [IN_W-1:0] last_val;
  logic [HW-1:0]   holdoff;
  logic [3:0]      cnt;
  logic            pend;
  logic            capture;

  function automatic logic [19:0] add3(input logic [19:0] b);
    for (int i = 0; i < 5; i++)
      if (b[4*i +: 4] >= 4'd5) b[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return b;
  endfunction

  always_comb begin
    state_n = state;
    capture = 1'b0;
    case (state)
      IDLE:
        if (holdoff == '0 && (bus.duty_in != last_val || bus.force_req || pend)) begin
          capture = 1'b1;
          state_n = SHIFT;
        end
      SHIFT:   if (cnt == CNT_LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      last_val  <= '0;
      holdoff   <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      bus.bcd   <= '0;
      bus.over  <= 1'b0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      state     <= state_n;
      bus.valid <= 1'b0;
      // holdoff runs in every state so the next start is spaced from this one
      if (capture)              holdoff <= HO_INIT;
      else if (holdoff != '0)   holdoff <= holdoff - 1'b1;
      // any force that does not start a conversion right now is remembered once
      pend <= capture ? 1'b0 : (pend | bus.force_req);
      case (state)
        IDLE:
          if (capture) begin
            sreg     <= {20'b0, bus.duty_in};
            last_val <= bus.duty_in;
            bus.busy <= 1'b1;
            cnt      <= '0;
          end
        SHIFT: begin
          sreg <= {add3(sreg[SW-1:IN_W]), sreg[IN_W-1:0]} << 1;
          cnt  <= cnt + 1'b1;
        end
        DONE: begin
          bus.bcd   <= sreg[SW-1:IN_W];
          bus.over  <= (last_val > IN_W'(MAX_VAL));
          bus.valid <= 1'b1;
          bus.busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_duty_bcd_conv.sv
// Directed bench for duty_bcd_conv with a short holdoff (UPDATE_DIV=20).
module tb_duty_bcd_conv;
  logic clk, rst_n;
  int   n_chk, n_pass;

  duty_bcd_if bus();
  duty_bcd_conv #(.IN_W(16), .MAX_VAL(1000), .UPDATE_DIV(20)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs n clocks; cycle i=1 is the first edge after the call. Records valids.
  task automatic win(input int n,
                     input int c1_at, input logic [15:0] c1_v,
                     input int c2_at, input logic [15:0] c2_v,
                     input int fp1, input int fp2,
                     output int nv, output int first_at,
                     output logic [19:0] b0, output logic [19:0] b1,
                     output logic busy1);
    nv = 0; first_at = -1; b0 = '0; b1 = '0; busy1 = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == 1) busy1 = bus.busy;
      if (i == c1_at) bus.duty_in = c1_v;
      if (i == c2_at) bus.duty_in = c2_v;
      bus.force_req = (i == fp1) || (i == fp2);
      if (bus.valid) begin
        if (nv == 0) begin first_at = i; b0 = bus.bcd; end
        else if (nv == 1) b1 = bus.bcd;
        nv++;
      end
    end
  endtask

  task automatic conv(input string tag, input logic [15:0] v,
                      input logic [19:0] exp_bcd, input logic exp_over);
    int nv, fa; logic [19:0] b0, b1; logic bz;
    bus.duty_in = v;
    win(30, 0, 16'd0, 0, 16'd0, 0, 0, nv, fa, b0, b1, bz);
    chk({tag, "_busy"}, 32'(bz), 32'd1);
    chk({tag, "_nvalid"}, 32'(nv), 32'd1);
    chk({tag, "_lat"}, 32'(fa), 32'd18);
    chk({tag, "_bcd"}, 32'(b0), 32'(exp_bcd));
    chk({tag, "_over"}, 32'(bus.over), 32'(exp_over));
  endtask

  initial begin
    int nv, fa; logic [19:0] b0, b1; logic bz;
    n_chk = 0; n_pass = 0;
    bus.duty_in = 16'd0; bus.force_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bcd", 32'(bus.bcd), 32'd0);
    chk("rst_over", 32'(bus.over), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // zero after reset matches last_val: nothing happens
    win(25, 0, 16'd0, 0, 16'd0, 0, 0, nv, fa, b0, b1, bz);
    chk("zero_no_trig", 32'(nv), 32'd0);

    conv("v500", 16'd500, 20'h00500, 1'b0);
    conv("v1000", 16'd1000, 20'h01000, 1'b0);
    conv("v1001", 16'd1001, 20'h01001, 1'b1);
    conv("v65535", 16'd65535, 20'h65535, 1'b1);
    conv("v0", 16'd0, 20'h00000, 1'b0);

    // holdoff: 456 is overwritten before the second start
    bus.duty_in = 16'd123;
    win(60, 4, 16'd456, 6, 16'd789, 0, 0, nv, fa, b0, b1, bz);
    chk("ho_nvalid", 32'(nv), 32'd2);
    chk("ho_first", 32'(b0), 32'h00123);
    chk("ho_second", 32'(b1), 32'h00789);

    // force start, then two forces while busy -> exactly one extra conversion
    bus.force_req = 1'b1;
    win(70, 0, 16'd0, 0, 16'd0, 4, 7, nv, fa, b0, b1, bz);
    chk("frc_nvalid", 32'(nv), 32'd2);
    chk("frc_lat", 32'(fa), 32'd18);
    chk("frc_bcd0", 32'(b0), 32'h00789);
    chk("frc_bcd1", 32'(b1), 32'h00789);

    // force and value change together -> single conversion
    bus.duty_in = 16'd250; bus.force_req = 1'b1;
    win(45, 0, 16'd0, 0, 16'd0, 0, 0, nv, fa, b0, b1, bz);
    chk("frcchg_nvalid", 32'(nv), 32'd1);
    chk("frcchg_bcd", 32'(b0), 32'h00250);

    // reset at E8 abandons the conversion
    bus.duty_in = 16'd42;
    win(9, 0, 16'd0, 0, 16'd0, 0, 0, nv, fa, b0, b1, bz);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bcd", 32'(bus.bcd), 32'd0);
    chk("mid_rst_over", 32'(bus.over), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    win(30, 0, 16'd0, 0, 16'd0, 0, 0, nv, fa, b0, b1, bz);
    chk("post_rst_nvalid", 32'(nv), 32'd1);
    chk("post_rst_lat", 32'(fa), 32'd18);
    chk("post_rst_bcd", 32'(b0), 32'h00042);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
